// File: rtl/pulse_train_ctrl.sv
// Command-driven pulse train generator: accepts (period, count) over valid/ready,
// emits count one-cycle strobes spaced period clocks apart, then strobes DONE.
module pulse_train_ctrl #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 CLK_IN,
  input  logic                 RST_IN,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic [DIV_WIDTH-1:0] CMD_DIV,
  input  logic [CNT_WIDTH-1:0] CMD_COUNT,
  input  logic                 ABORT,
  output logic                 PULSE_OUT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CNT_WIDTH-1:0] PULSES_LEFT
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(2);

  state_t               state;
  logic [DIV_WIDTH-1:0] div;
  logic [DIV_WIDTH-1:0] counter;
  logic [DIV_WIDTH-1:0] div_last;

  assign div_last  = div - DIV_WIDTH'(1);
  assign CMD_READY = (state == IDLE) & ~RST_IN;
  assign BUSY      = (state != IDLE);

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state       <= IDLE;
      div         <= '0;
      counter     <= '0;
      PULSE_OUT   <= 1'b0;
      DONE        <= 1'b0;
      PULSES_LEFT <= '0;
    end else begin
      case (state)
        IDLE: begin
          PULSE_OUT <= 1'b0;
          DONE      <= 1'b0;
          if (CMD_VALID) begin
            // Periods below 2 are clamped so the counter always has a distinct terminal value.
            div         <= (CMD_DIV < MIN_DIV) ? MIN_DIV : CMD_DIV;
            PULSES_LEFT <= CMD_COUNT;
            counter     <= '0;
            state       <= (CMD_COUNT == '0) ? FINISH : RUN;
          end
        end

        RUN: begin
          DONE <= 1'b0;
          if (ABORT) begin
            state       <= IDLE;
            counter     <= '0;
            PULSES_LEFT <= '0;
            PULSE_OUT   <= 1'b0;
          end else if (counter == div_last) begin
            counter     <= '0;
            PULSE_OUT   <= 1'b1;
            PULSES_LEFT <= PULSES_LEFT - CNT_WIDTH'(1);
            if (PULSES_LEFT == CNT_WIDTH'(1)) begin
              state <= FINISH;
            end
          end else begin
            counter   <= counter + DIV_WIDTH'(1);
            PULSE_OUT <= 1'b0;
          end
        end

        FINISH: begin
          PULSE_OUT <= 1'b0;
          state     <= IDLE;
          if (ABORT) begin
            counter     <= '0;
            PULSES_LEFT <= '0;
            DONE        <= 1'b0;
          end else begin
            DONE <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          PULSE_OUT <= 1'b0;
          DONE      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// Scoreboard bench for pulse_train_ctrl: stimulus schedules expected pulse/done events
// by edge number; a monitor pops and compares them whenever the DUT strobes.
module tb_pulse_train_ctrl;
  localparam int DW = 16;
  localparam int CW = 8;

  logic          CLK_IN = 1'b0;
  logic          RST_IN;
  logic          CMD_VALID;
  logic          CMD_READY;
  logic [DW-1:0] CMD_DIV;
  logic [CW-1:0] CMD_COUNT;
  logic          ABORT;
  logic          PULSE_OUT;
  logic          BUSY;
  logic          DONE;
  logic [CW-1:0] PULSES_LEFT;

  pulse_train_ctrl #(.DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK_IN(CLK_IN), .RST_IN(RST_IN), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_DIV(CMD_DIV), .CMD_COUNT(CMD_COUNT), .ABORT(ABORT), .PULSE_OUT(PULSE_OUT),
    .BUSY(BUSY), .DONE(DONE), .PULSES_LEFT(PULSES_LEFT)
  );

  always #5 CLK_IN = ~CLK_IN;

  typedef struct {
    bit is_done;
    int at;
    int left;
  } ev_t;

  ev_t q[$];
  int  edge_n = 0;
  int  busy_until = 0;
  int  last_e0 = 0;
  int  checks = 0;
  int  failures = 0;
  bit  mon_en = 1'b0;

  always @(posedge CLK_IN) edge_n <= edge_n + 1;

  // Monitor: every strobe must match the oldest scheduled event.
  always @(negedge CLK_IN) begin
    if (mon_en && !RST_IN) begin
      ev_t e;
      if (PULSE_OUT && DONE) begin
        checks++; failures++;
        $display("FAIL overlap edge %0d: got pulse=1 done=1, expected never both", edge_n);
      end
      while (q.size() > 0 && q[0].at < edge_n) begin
        checks++; failures++;
        $display("FAIL missing_event edge %0d: got none, expected %s at edge %0d",
                 edge_n, q[0].is_done ? "done" : "pulse", q[0].at);
        void'(q.pop_front());
      end
      if (PULSE_OUT || DONE) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe edge %0d: got pulse=%0b done=%0b, expected none",
                   edge_n, PULSE_OUT, DONE);
        end else begin
          e = q.pop_front();
          if (e.is_done != DONE || e.at != edge_n || e.left != int'(PULSES_LEFT)) begin
            failures++;
            $display("FAIL strobe edge %0d: got done=%0b left=%0d, expected done=%0b edge=%0d left=%0d",
                     edge_n, DONE, PULSES_LEFT, e.is_done, e.at, e.left);
          end
        end
      end
    end
  end

  // One cycle of stimulus; the model decides acceptance and schedules events.
  task automatic drive(input bit v, input int d, input int c, input bit ab);
    bit mready;
    bit aborting;
    int dv;
    mready = (edge_n >= busy_until);
    checks++;
    if (CMD_READY !== mready || BUSY !== !mready) begin
      failures++;
      $display("FAIL ready_busy edge %0d: got ready=%0b busy=%0b, expected ready=%0b busy=%0b",
               edge_n, CMD_READY, BUSY, mready, !mready);
    end
    CMD_VALID = v;
    CMD_DIV   = DW'(d);
    CMD_COUNT = CW'(c);
    ABORT     = ab;
    aborting  = 1'b0;
    if (v && mready) begin
      last_e0 = edge_n + 1;
      dv = (d < 2) ? 2 : d;
      for (int k = 1; k <= c; k++) q.push_back('{1'b0, last_e0 + k * dv, c - k});
      busy_until = last_e0 + c * dv + 1;
      q.push_back('{1'b1, busy_until, 0});
    end else if (ab && !mready) begin
      ev_t keep[$];
      foreach (q[i]) if (q[i].at <= edge_n) keep.push_back(q[i]);
      q = keep;
      busy_until = edge_n + 1;
      aborting = 1'b1;
    end
    @(negedge CLK_IN);
    if (aborting) begin
      checks++;
      if (PULSES_LEFT !== '0 || PULSE_OUT !== 1'b0 || DONE !== 1'b0) begin
        failures++;
        $display("FAIL abort_state edge %0d: got left=%0d pulse=%0b done=%0b, expected 0/0/0",
                 edge_n, PULSES_LEFT, PULSE_OUT, DONE);
      end
    end
  endtask

  task automatic idle_until(input int target);
    for (int i = 0; i < 5000 && edge_n < target; i++) drive(1'b0, 0, 0, 1'b0);
    if (edge_n < target) begin
      checks++; failures++;
      $display("FAIL timeout edge %0d: got still waiting, expected edge %0d", edge_n, target);
    end
  endtask

  task automatic check_reset_outputs(input string name, input bit exp_ready);
    checks++;
    if (PULSE_OUT !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0 || PULSES_LEFT !== '0 ||
        CMD_READY !== exp_ready) begin
      failures++;
      $display("FAIL %s: got pulse=%0b done=%0b busy=%0b left=%0d ready=%0b, expected 0/0/0/0/%0b",
               name, PULSE_OUT, DONE, BUSY, PULSES_LEFT, CMD_READY, exp_ready);
    end
  endtask

  initial begin
    int e0;
    RST_IN = 1'b1; CMD_VALID = 1'b0; CMD_DIV = '0; CMD_COUNT = '0; ABORT = 1'b0;
    repeat (3) @(negedge CLK_IN);
    check_reset_outputs("reset_state", 1'b0);
    RST_IN = 1'b0;
    mon_en = 1'b1;
    #1 check_reset_outputs("after_reset_release", 1'b1);
    @(negedge CLK_IN);
    drive(1'b0, 0, 0, 1'b0);

    // Reset asserted while the first pulse of a train is on the output.
    drive(1'b1, 3, 5, 1'b0);
    e0 = last_e0;
    idle_until(e0 + 3);
    #2 RST_IN = 1'b1;
    q.delete();
    busy_until = 0;
    #1 check_reset_outputs("reset_mid_run", 1'b0);
    repeat (2) @(negedge CLK_IN);
    RST_IN = 1'b0;
    #1 check_reset_outputs("ready_after_mid_run_reset", 1'b1);
    @(negedge CLK_IN);

    drive(1'b1, 5, 3, 1'b0);  idle_until(busy_until);
    drive(1'b1, 0, 2, 1'b0);  idle_until(busy_until);
    drive(1'b1, 1, 2, 1'b0);  idle_until(busy_until);
    drive(1'b1, 9, 0, 1'b0);  idle_until(busy_until);

    // Abort on the edge that would emit pulse 3.
    drive(1'b1, 4, 10, 1'b0);
    e0 = last_e0;
    idle_until(e0 + 11);
    drive(1'b0, 0, 0, 1'b1);
    drive(1'b0, 0, 0, 1'b0);
    idle_until(busy_until);

    // Back-to-back: second command held valid through the first train.
    drive(1'b1, 3, 4, 1'b0);
    for (int i = 0; i < 100 && edge_n < busy_until; i++) drive(1'b1, 5, 3, 1'b0);
    drive(1'b1, 5, 3, 1'b0);
    idle_until(busy_until);

    repeat (300) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 7), $urandom_range(0, 5),
            $urandom_range(0, 19) == 0);
    end
    idle_until(busy_until);
    repeat (3) drive(1'b0, 0, 0, 1'b0);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending events, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
